// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-and-add multiplier that sequences one external combinational ALU.
// Latency: n+1 cycles from operand acceptance to out_valid, the same for every operand value.
// Backpressure: one operation in flight; in_ready stays low until the product is taken by out_ready.
// Optional feature: define MUL_OVF_FLAG_EN to add the out_ovf port (product wider than n bits).

module alu_mul_seq #(
  parameter int         n       = 4,
  parameter logic [2:0] CNT_ADD = 3'b010
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   in_a,
  input  logic [n-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] out_p,
`ifdef MUL_OVF_FLAG_EN
  output logic           out_ovf,
`endif
  output logic [2:0]     alu_cntrl,
  output logic [n-1:0]   alu_a,
  output logic [n-1:0]   alu_b,
  input  logic [n-1:0]   alu_f,
  input  logic           alu_cout
);

  localparam int CW = $clog2(n + 1);

  // cnt counts completed add/shift steps; reaching n means the product is complete.
  localparam logic [CW-1:0] CNT_LAST = CW'(n);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [n-1:0]  mcand;
  logic [n-1:0]  acc;
  logic [n-1:0]  q;
  logic [CW-1:0] cnt;
  logic          shifting;

  // The ALU is only given real operands while an add/shift step is in progress;
  // the writeback cycle and the idle/done states present zeros.
  assign shifting  = (state == CALC) && (cnt != CNT_LAST);

  assign alu_cntrl = CNT_ADD;
  assign alu_a     = shifting ? acc : '0;
  assign alu_b     = shifting ? (mcand & {n{q[0]}}) : '0;

`ifdef MUL_OVF_FLAG_EN
  // out_p is cleared outside DONE, so the flag is automatically 0 there as well.
  assign out_ovf = |out_p[2*n-1:n];
`endif

  // Sequencer: operand capture, n add/shift steps through the ALU, product hold until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= in_a;
            q        <= in_b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          if (cnt != CNT_LAST) begin
            // The n+1-bit ALU sum replaces the high half; q shifts right and
            // drops the multiplier bit just consumed, so the carry is kept.
            {acc, q} <= {alu_cout, alu_f, q[n-1:1]};
            cnt      <= cnt + CNT_ONE;
          end else begin
            out_p     <= {acc, q};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_p     <= '0;
        end
      endcase
    end
  end

endmodule
